// File: rtl/serial_add_if.sv
// serial_add_if: start/busy/done handshake and operand/result bus for serial_add_ctrl (sub port under SERIAL_ADD_SUB_EN)
interface serial_add_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_SUB_EN
    modport master(output start, a, b, sub, input busy, done, sum, cout);
    modport slave(input start, a, b, sub, output busy, done, sum, cout);
`else
    modport master(output start, a, b, input busy, done, sum, cout);
    modport slave(input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder sharing one full-adder cell, LSB first (SERIAL_ADD_SUB_EN adds subtraction)
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input logic        clk,
    input logic        rst,
    serial_add_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, sum_r;
    logic [CW-1:0]    cnt;
    logic             carry, cout_r, s, c_nx, last, accept;
    assign s      = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_nx   = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign last   = cnt == CW'(WIDTH - 1);
    assign accept = state == IDLE && bus.start;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = (state == IDLE) ? (bus.start ? RUN : IDLE) :
                   (state == RUN)  ? (last ? DONE : RUN) : IDLE;
        bus.busy = state == RUN;
        bus.done = state == DONE;
    end
    // Result bits enter at the MSB so that after WIDTH shifts bit 0 lands in sum[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_r  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
        end else if (accept) begin
            a_sr  <= bus.a;
            cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
            b_sr  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
`else
            b_sr  <= bus.b;
            carry <= 1'b0;
`endif
        end else if (state == RUN) begin
            sum_r <= {s, sum_r[WIDTH-1:1]};
            carry <= c_nx;
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            cnt   <= cnt + CW'(1);
            if (last) cout_r <= c_nx;
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: vector table, corner sequences and random ops against an arithmetic model of serial_add_ctrl
module tb_serial_add_ctrl;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    serial_add_if #(.WIDTH(W)) bus ();
    serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [8:0] r;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] av, input logic [7:0] bv, input logic sv);
        logic [7:0] d;
        d = av - bv;
        return sv ? {av >= bv, d} : {1'b0, av} + {1'b0, bv};
    endfunction

    task automatic drive(input logic st, input logic [7:0] av, input logic [7:0] bv, input logic sv);
        bus.start = st;
        bus.a = av;
        bus.b = bv;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = sv;
`else
        if (sv) $display("sub requested without SERIAL_ADD_SUB_EN");
`endif
    endtask

    // Entered at a negedge with the DUT idle; leaves at a negedge with the DUT idle.
    task automatic op(input logic [7:0] av, input logic [7:0] bv, input logic sv, input logic [8:0] exp);
        int n, nb;
        drive(1'b1, av, bv, sv);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        n = 0;
        nb = 0;
        while (!bus.done && n < 40) begin
            nb += int'(bus.busy);
            n++;
            @(negedge clk);
        end
        chk("latency", n, W);
        chk("busy_cycles", nb, W);
        chk("busy_in_done", bus.busy, 0);
        chk("sum", bus.sum, exp[7:0]);
        chk("cout", bus.cout, exp[8]);
        @(negedge clk);
        chk("done_pulse", bus.done, 0);
    endtask

    initial begin
        int nd, last_i;
        rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        rst = 1'b0;
        @(negedge clk);

        vt.push_back('{8'h0F, 8'h01, 1'b0, 9'h010});
        vt.push_back('{8'hFF, 8'h01, 1'b0, 9'h100});
        vt.push_back('{8'hFF, 8'hFF, 1'b0, 9'h1FE});
        vt.push_back('{8'h12, 8'h34, 1'b0, 9'h046});
        vt.push_back('{8'h80, 8'h80, 1'b0, 9'h100});
        vt.push_back('{8'h00, 8'h00, 1'b0, 9'h000});
        vt.push_back('{8'hAA, 8'h55, 1'b0, 9'h0FF});
`ifdef SERIAL_ADD_SUB_EN
        vt.push_back('{8'h05, 8'h07, 1'b1, 9'h0FE});
        vt.push_back('{8'h07, 8'h05, 1'b1, 9'h102});
        vt.push_back('{8'h33, 8'h33, 1'b1, 9'h100});
`endif
        for (int i = 0; i < vt.size(); i++) op(vt[i].a, vt[i].b, vt[i].sub, vt[i].r);

        // start pulsed during RUN must be ignored
        drive(1'b1, 8'h0F, 8'h01, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 8'h0F, 8'h01, 1'b0);
        repeat (2) @(negedge clk);
        drive(1'b1, 8'h55, 8'h55, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h55, 8'h55, 1'b0);
        nd = 0;
        while (!bus.done && nd < 40) begin
            nd++;
            @(negedge clk);
        end
        chk("ign_done_seen", bus.done, 1);
        chk("ign_sum", bus.sum, 8'h10);
        chk("ign_cout", bus.cout, 0);
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            nd += int'(bus.done);
        end
        chk("ign_no_second_done", nd, 0);

        // reset in RUN cycle 4 aborts without a done pulse
        drive(1'b1, 8'hFF, 8'hFF, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 8'hFF, 8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_sum", bus.sum, 0);
        chk("abort_cout", bus.cout, 0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            nd += int'(bus.done | bus.busy);
        end
        chk("abort_quiet", nd, 0);
        op(8'h12, 8'h34, 1'b0, 9'h046);

        // start held high: one accept every W+2 cycles
        drive(1'b1, 8'h80, 8'h80, 1'b0);
        @(posedge clk);
        nd = 0;
        last_i = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                chk("held_sum", bus.sum, 8'h00);
                chk("held_cout", bus.cout, 1);
                if (last_i >= 0) chk("held_interval", i - last_i, W + 2);
                else chk("held_first", i, W);
                last_i = i;
                nd++;
            end
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        chk("held_count", nd, 4);
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            logic [7:0] av, bv;
            logic sv;
            av = 8'($urandom);
            bv = 8'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            sv = 1'($urandom);
`else
            sv = 1'b0;
`endif
            op(av, bv, sv, model(av, bv, sv));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
